mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates one shared memory port between the instruction-fetch unit and the load/store unit of the RV32I core. It holds a two-state ownership FSM, drives the select line of the 2:1 32-bit address/data muxes in front of the memory, and routes the memory acknowledge and read data back to the owning requester. It sits between the fetch/LSU stages and the single-ported memory.

## Interface
- Parameters:
- `ADDR_W`, default 32, address width.
- `DATA_W`, default 32, data width.
- Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request, held until `if_ack`.
- `if_addr`  in  ADDR_W  fetch address, stable while `if_req`.
- `if_ack`  out  1  one-cycle completion pulse to fetch.
- `d_req`  in  1  data request, held until `d_ack`.
- `d_we`  in  1  data write enable, stable while `d_req`.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_wstrb`  in  4  byte strobes.
- `d_ack`  out  1  one-cycle completion pulse to LSU.
- `rdata`  out  DATA_W  read data for the owner, valid with its ack.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_wstrb`  out  4  memory strobes.
- `mem_ack`  in  1  memory completion pulse; read data valid this cycle.
- `mem_rdata`  in  DATA_W  memory read data.
- `sel`  out  1  registered owner: 0 = fetch, 1 = data.

## Operation
- States: IDLE, OWN_I, OWN_D.
- IDLE:
  - Winner chosen combinationally from `if_req`/`d_req`.
  - Next edge enters OWN_I or OWN_D and registers `sel`.
  - With no request, stays in IDLE.
- OWN_x:
  - `mem_req`=1; `mem_addr` = `sel` ? `d_addr` : `if_addr`.
  - `mem_we` = `sel` & `d_we`; `mem_wstrb` = `sel` ? `d_wstrb` : 0.
  - `mem_wdata` = `d_wdata` unconditionally.
- Completion:
  - On `mem_ack` in OWN_x, the owner's ack = `mem_ack` (combinational, same cycle).
  - `rdata` = `mem_rdata` passthrough in all states.
  - Next state is IDLE; there is no direct owner-to-owner transition.
- Ownership is held until `mem_ack`:
  - A requester dropping `req` mid-transaction is a protocol violation.
  - The arbiter ignores the drop and still completes and acks.
- `mem_ack` in IDLE is ignored; neither ack fires.
- Default arbitration is fixed priority: data beats fetch on a simultaneous request.

## Timing
- Reset values: state IDLE, `sel`=0, `mem_req`=0, `mem_we`=0, `mem_wstrb`=0, `if_ack`=0, `d_ack`=0.
- Reset asserted mid-transaction:
  - Returns to IDLE asynchronously; `mem_req` falls in the same cycle.
  - No ack is generated; requesters re-issue.
- Latency, measured from `req` rise at cycle 0 (first edge seen):
  - `mem_req` high in cycle 1.
  - With `mem_ack` in cycle 1, ack appears in cycle 1.
  - Minimum 2 cycles per transaction, including the IDLE cycle.
- Memory wait states extend OWN_x indefinitely; no timeout.
- Back-to-back transactions from either requester take 2 cycles each; throughput is ≤ 1 access per 2 cycles.

## Configuration
- `ARB_ROUND_ROBIN_EN`:
  - Defined: a 1-bit last-served flag updates on every ack.
  - On a simultaneous request in IDLE, the requester not served last wins.
  - Flag reset value = fetch-served, so data wins the first tie.
  - Undefined: fixed data-over-fetch priority; the flag is absent.

## Structure
- Shared package `mem_arb_pkg`: state enum (IDLE/OWN_I/OWN_D), `SEL_IF`=0, `SEL_D`=1 constants, strobe width 4.
- Datapath steering reuses the existing 32-bit 2:1 mux module for `mem_addr`, driven by `sel`.
- One natural sub-module: `arb_pick`, the combinational winner selection, with and without round-robin.
- FSM and ack routing stay in the top module.

## Test plan
- Single fetch: `if_req`=1 with `if_addr`=0x0000_0100; memory acks in cycle 1 with 0x0000_0013 -> `mem_addr`=0x100, `if_ack` pulse in cycle 1, `rdata`=0x13, `d_ack`=0.
- Store with 3 wait states: `d_req`, `d_we`=1, `d_addr`=0x2000, `d_wdata`=0xDEADBEEF, `d_wstrb`=0xF -> `mem_we`=1 for cycles 1–4, `d_ack` in cycle 4 only, then IDLE.
- Simultaneous requests, fixed priority: both at cycle 0 -> data served cycles 1–1, IDLE in cycle 2, fetch owns from cycle 3, `sel` sequence 1 then 0.
- `ARB_ROUND_ROBIN_EN` with both held continuously -> grants alternate D, I, D, I, with 4 acks in 8 cycles given a zero-wait memory.
- Reset mid-transaction: `rst` pulsed during OWN_D wait -> `mem_req`=0 immediately, no `d_ack`; after release a new `d_req` completes normally.
- Spurious `mem_ack` in IDLE -> no ack output, state stays IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the memory port arbiter: the ownership state
//   encoding, the select-line constants and the byte-strobe width.
//   Build option: ARB_ROUND_ROBIN_EN (see mem_port_arbiter.sv).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } arb_state_e;

    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_D  = 1'b1;
    localparam int   STRB_W = 4;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// arb_pick
//   Combinational winner selection between fetch and data requests.
//   Without ARB_ROUND_ROBIN_EN data always beats fetch on a tie. With
//   ARB_ROUND_ROBIN_EN a tie goes to the requester not served last.
//   Ports:
//     if_req_i  fetch request
//     d_req_i   data request
//     last_i    last-served owner (ARB_ROUND_ROBIN_EN builds only)
//     valid_o   at least one request pending
//     grant_o   winner: SEL_IF or SEL_D
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req_i,
    input  logic d_req_i,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic last_i,
`endif
    output logic valid_o,
    output logic grant_o
);

    assign valid_o = if_req_i | d_req_i;

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        grant_o = d_req_i ? SEL_D : SEL_IF;
        if (if_req_i && d_req_i) begin
            grant_o = ~last_i;
        end
    end
`else
    assign grant_o = d_req_i ? SEL_D : SEL_IF;
`endif

endmodule

// File: rtl/mux2_32.sv
// mux2_32
//   Generic 2:1 mux, 32 bits wide by default, used to steer the memory
//   address from either requester.
//   Ports:
//     a0_i  selected when s_i = 0
//     a1_i  selected when s_i = 1
//     s_i   select
//     y_o   mux output
module mux2_32 #(
    parameter int W = 32
) (
    input  logic [W-1:0] a0_i,
    input  logic [W-1:0] a1_i,
    input  logic         s_i,
    output logic [W-1:0] y_o
);

    assign y_o = s_i ? a1_i : a0_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch and the load/store
//   unit. A winner is picked in IDLE, ownership is held until mem_ack,
//   and the ack is routed back to the owner in the same cycle. Every
//   transaction passes through IDLE, so throughput is at most one access
//   per two cycles.
//   Build option: ARB_ROUND_ROBIN_EN enables round-robin tie breaking.
//   Ports:
//     clk, rst                     clock, async active-high reset
//     if_req/if_addr/if_ack        fetch request channel
//     d_req/d_we/d_addr/d_wdata/d_wstrb/d_ack   data request channel
//     rdata                        read data, passthrough of mem_rdata
//     mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb  memory request
//     mem_ack/mem_rdata            memory response
//     sel                          registered owner, 0 = fetch, 1 = data
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [STRB_W-1:0] d_wstrb,
    output logic              d_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              sel
);

    arb_state_e state_q, state_d;
    logic       sel_q, sel_d;
    logic       pick_valid, pick_grant;
    logic       own;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
`endif

    arb_pick u_pick (
        .if_req_i (if_req),
        .d_req_i  (d_req),
`ifdef ARB_ROUND_ROBIN_EN
        .last_i   (last_q),
`endif
        .valid_o  (pick_valid),
        .grant_o  (pick_grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= SEL_IF;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = (pick_grant == SEL_D) ? OWN_D : OWN_I;
                    sel_d   = pick_grant;
                end
            end
            // A requester dropping req here is ignored; only mem_ack ends ownership.
            OWN_I, OWN_D: begin
                if (mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Reset to fetch-served so the first tie goes to data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= SEL_IF;
        else     last_q <= last_d;
    end

    always_comb begin
        last_d = last_q;
        if (d_ack)       last_d = SEL_D;
        else if (if_ack) last_d = SEL_IF;
    end
`endif

    assign own       = (state_q != IDLE);
    assign mem_req   = own;
    // sel holds its value through IDLE, so write controls are also gated by ownership.
    assign mem_we    = own & (sel_q == SEL_D) & d_we;
    assign mem_wstrb = (own && sel_q == SEL_D) ? d_wstrb : '0;
    assign mem_wdata = d_wdata;
    assign if_ack    = (state_q == OWN_I) & mem_ack;
    assign d_ack     = (state_q == OWN_D) & mem_ack;
    assign rdata     = mem_rdata;
    assign sel       = sel_q;

    mux2_32 #(.W(ADDR_W)) u_addr_mux (
        .a0_i (if_addr),
        .a1_i (d_addr),
        .s_i  (sel_q),
        .y_o  (mem_addr)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Cycle k starts at rising edge k;
//   inputs change 1 ns after the edge and outputs are sampled 1 ns later.
module tb_mem_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ack;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic        mem_ack_drv;
    logic        auto_ack;
    logic [31:0] mem_rdata;
    logic        sel;

    int vectors = 0;
    int miscompares = 0;

    // Zero-wait memory when auto_ack is set.
    assign mem_ack = auto_ack ? mem_req : mem_ack_drv;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_ack     (d_ack),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .sel       (sel)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; d_wstrb = 0; mem_ack_drv = 0; auto_ack = 0; mem_rdata = 0;
        #2;
        vectors++; if (sel !== 1'b0) begin miscompares++; $display("FAIL reset_sel: got %0h expected 0", sel); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %0h expected 0", mem_req); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %0h expected 0", mem_we); end
        vectors++; if (mem_wstrb !== 4'h0) begin miscompares++; $display("FAIL reset_mem_wstrb: got %0h expected 0", mem_wstrb); end
        vectors++; if ({if_ack, d_ack} !== 2'b00) begin miscompares++; $display("FAIL reset_acks: got %0b expected 00", {if_ack, d_ack}); end
        tick();
        rst = 1'b0;
        #1;
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL post_reset_mem_req: got %0h expected 0", mem_req); end
    endtask

    // Both request in cycle 0: data owns cycle 1, IDLE cycle 2, fetch owns cycle 3.
    task automatic test_simultaneous();
        if_req = 1; if_addr = 32'h0000_0300; d_req = 1; d_we = 0; d_addr = 32'h0000_0400;
        tick();
        mem_ack_drv = 1; mem_rdata = 32'h0000_00AA; #1;
        vectors++; if (sel !== 1'b1) begin miscompares++; $display("FAIL sim_c1_sel: got %0h expected 1", sel); end
        vectors++; if (mem_addr !== 32'h400) begin miscompares++; $display("FAIL sim_c1_addr: got %0h expected 400", mem_addr); end
        vectors++; if ({if_ack, d_ack} !== 2'b01) begin miscompares++; $display("FAIL sim_c1_acks: got %0b expected 01", {if_ack, d_ack}); end
        vectors++; if (rdata !== 32'hAA) begin miscompares++; $display("FAIL sim_c1_rdata: got %0h expected aa", rdata); end
        tick();
        d_req = 0; mem_ack_drv = 0; #1;
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL sim_c2_idle: got %0h expected 0", mem_req); end
        tick();
        #1;
        vectors++; if (sel !== 1'b0) begin miscompares++; $display("FAIL sim_c3_sel: got %0h expected 0", sel); end
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL sim_c3_mem_req: got %0h expected 1", mem_req); end
        vectors++; if (mem_addr !== 32'h300) begin miscompares++; $display("FAIL sim_c3_addr: got %0h expected 300", mem_addr); end
        mem_ack_drv = 1; #1;
        vectors++; if ({if_ack, d_ack} !== 2'b10) begin miscompares++; $display("FAIL sim_c3_acks: got %0b expected 10", {if_ack, d_ack}); end
        tick();
        if_req = 0; mem_ack_drv = 0;
    endtask

    task automatic test_single_fetch();
        if_req = 1; if_addr = 32'h0000_0100;
        tick();
        mem_ack_drv = 1; mem_rdata = 32'h0000_0013; #1;
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL fetch_mem_req: got %0h expected 1", mem_req); end
        vectors++; if (mem_addr !== 32'h100) begin miscompares++; $display("FAIL fetch_addr: got %0h expected 100", mem_addr); end
        vectors++; if (if_ack !== 1'b1) begin miscompares++; $display("FAIL fetch_if_ack: got %0h expected 1", if_ack); end
        vectors++; if (d_ack !== 1'b0) begin miscompares++; $display("FAIL fetch_d_ack: got %0h expected 0", d_ack); end
        vectors++; if (rdata !== 32'h13) begin miscompares++; $display("FAIL fetch_rdata: got %0h expected 13", rdata); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL fetch_mem_we: got %0h expected 0", mem_we); end
        tick();
        if_req = 0; mem_ack_drv = 0; #1;
        vectors++; if ({mem_req, if_ack} !== 2'b00) begin miscompares++; $display("FAIL fetch_c2: got %0b expected 00", {mem_req, if_ack}); end
    endtask

    // Both held continuously with a zero-wait memory for 8 cycles.
    task automatic test_back_to_back();
        bit g[8];
        int n = 0;
        if_req = 1; d_req = 1; d_we = 0; auto_ack = 1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            #1;
            if (d_ack && n < 8) begin g[n] = 1'b1; n++; end
            if (if_ack && n < 8) begin g[n] = 1'b0; n++; end
        end
        if_req = 0; d_req = 0; auto_ack = 0;
        vectors++; if (n !== 4) begin miscompares++; $display("FAIL b2b_ack_count: got %0d expected 4", n); end
        for (int i = 0; i < 4; i++) begin
            bit exp_d;
            exp_d = RR ? (i % 2 == 0) : 1'b1;
            vectors++; if (i < n && g[i] !== exp_d) begin miscompares++; $display("FAIL b2b_grant%0d: got d=%0b expected d=%0b", i, g[i], exp_d); end
        end
        tick();
    endtask

    task automatic test_store_waits();
        d_req = 1; d_we = 1; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
        for (int c = 1; c <= 4; c++) begin
            tick();
            mem_ack_drv = (c == 4); #1;
            vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL store_c%0d_we: got %0h expected 1", c, mem_we); end
            vectors++; if (d_ack !== (c == 4)) begin miscompares++; $display("FAIL store_c%0d_ack: got %0h expected %0h", c, d_ack, (c == 4)); end
            vectors++; if ({mem_addr, mem_wdata, mem_wstrb} !== {32'h2000, 32'hDEADBEEF, 4'hF}) begin
                miscompares++; $display("FAIL store_c%0d_bus: got %0h/%0h/%0h expected 2000/deadbeef/f", c, mem_addr, mem_wdata, mem_wstrb);
            end
        end
        tick();
        d_req = 0; d_we = 0; mem_ack_drv = 0; #1;
        vectors++; if ({mem_req, mem_we, mem_wstrb} !== 6'b0) begin miscompares++; $display("FAIL store_idle: got %0b expected 0", {mem_req, mem_we, mem_wstrb}); end
    endtask

    task automatic test_reset_mid();
        d_req = 1; d_we = 0; d_addr = 32'h0000_0500;
        tick();
        #1;
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rmid_own: got %0h expected 1", mem_req); end
        tick();
        rst = 1; mem_ack_drv = 1; #1;
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rmid_mem_req: got %0h expected 0", mem_req); end
        vectors++; if (d_ack !== 1'b0) begin miscompares++; $display("FAIL rmid_d_ack: got %0h expected 0", d_ack); end
        rst = 0; mem_ack_drv = 0;
        tick();
        mem_ack_drv = 1; #1;
        vectors++; if ({mem_req, d_ack, mem_addr} !== {2'b11, 32'h500}) begin
            miscompares++; $display("FAIL rmid_retry: got req=%0b ack=%0b addr=%0h expected 1/1/500", mem_req, d_ack, mem_addr);
        end
        tick();
        d_req = 0; mem_ack_drv = 0;
    endtask

    task automatic test_spurious_ack();
        mem_ack_drv = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++; if ({mem_req, if_ack, d_ack} !== 3'b000) begin
                miscompares++; $display("FAIL spurious_c%0d: got %0b expected 000", c, {mem_req, if_ack, d_ack});
            end
        end
        mem_ack_drv = 0;
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_single_fetch();
        test_back_to_back();
        test_store_waits();
        test_reset_mid();
        test_spurious_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
